// File: rtl/l2norm_pkg.sv
// Shared defaults and format constants for the L2-norm sum-of-squares reducer.
package l2norm_pkg;

  localparam int unsigned DATA_W_DEF    = 32;
  localparam int unsigned ACC_W_DEF     = 64;

  // Input is Q16.16; a square of it lands exactly on the Q32.32 result grid.
  localparam int unsigned Q16_FRAC_BITS = 16;
  localparam int unsigned Q32_FRAC_BITS = 32;

  localparam logic [ACC_W_DEF-1:0] SAT_VALUE = '1;

  function automatic int unsigned cnt_width(input int unsigned vec_len);
    return (vec_len > 2) ? $clog2(vec_len) : 1;
  endfunction

endpackage

// File: rtl/l2norm_square_stage.sv
// S1 register stage: full-width square of the accepted element plus valid/last tags.
module l2norm_square_stage
  import l2norm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  load,
  input  logic [DATA_W-1:0]     data,
  input  logic                  last_in,
  output logic [2*DATA_W-1:0]   sq_reg,
  output logic                  sq_valid,
  output logic                  sq_last
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] data_ext;
  logic signed [PROD_W-1:0] prod;

  assign data_ext = PROD_W'($signed(data));
  assign prod     = data_ext * data_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_reg   <= '0;
      sq_valid <= 1'b0;
      sq_last  <= 1'b0;
    end else if (!hold) begin
      sq_valid <= load;
      if (load) begin
        sq_reg  <= prod;
        sq_last <= last_in;
      end
    end
  end

endmodule

// File: rtl/l2norm_sumsq_reduce_039.sv
// Streaming sum-of-squares reducer: one saturating Q32.32 result per VEC_LEN elements.
module l2norm_sumsq_reduce_039
  import l2norm_pkg::*;
#(
  parameter int unsigned VEC_LEN = 64,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [DATA_W-1:0] input_data,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [ACC_W-1:0]  sum_data,
  output logic              sat_out
);

  localparam int unsigned CNT_W  = cnt_width(VEC_LEN);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_SAT  = {ACC_W{SAT_VALUE[0]}};

  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("ACC_W must be >= 2*DATA_W");
  end
  if (VEC_LEN < 2 || VEC_LEN > 65536) begin : g_vec_len_check
    $error("VEC_LEN must be in 2..65536");
  end
  if (2 * Q16_FRAC_BITS != Q32_FRAC_BITS) begin : g_format_check
    $error("square of input format must match result format");
  end

  logic [CNT_W-1:0]  count;
  logic              stall;
  logic              accept;
  logic [PROD_W-1:0] sq_reg;
  logic              sq_valid;
  logic              sq_last;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [SUM_W-1:0]  acc_sum;
  logic              carry;
  logic              sat_flag;

  // Only a finished vector blocked by an unaccepted result can stall the pipe.
  assign stall    = sq_valid && sq_last && valid_out && !ready_out;
  assign ready_in = !stall;
  assign accept   = valid_in && ready_in;

  l2norm_square_stage #(
    .DATA_W (DATA_W)
  ) u_square (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (stall),
    .load     (accept),
    .data     (input_data),
    .last_in  (count == LAST_IDX),
    .sq_reg   (sq_reg),
    .sq_valid (sq_valid),
    .sq_last  (sq_last)
  );

  always_comb begin
    acc_sum  = {1'b0, acc} + SUM_W'(sq_reg);
    carry    = acc_sum[ACC_W];
    acc_next = carry ? ACC_SAT : acc_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (accept) begin
      count <= (count == LAST_IDX) ? '0 : count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sat_flag  <= 1'b0;
      sum_data  <= '0;
      sat_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
      // A new result loading on the handshake edge overrides the clear above.
      if (sq_valid && !stall) begin
        if (sq_last) begin
          sum_data  <= acc_next;
          sat_out   <= sat_flag | carry;
          valid_out <= 1'b1;
          acc       <= '0;
          sat_flag  <= 1'b0;
        end else begin
          acc      <= acc_next;
          sat_flag <= sat_flag | carry;
        end
      end
    end
  end

endmodule
